mult32x32_arbiter: RTL and testbench

- Shares one sequential mult32x32 unit between NUM_REQ requesters using round-robin arbitration.
- Latches the winning requester's operands and pulses the multiplier start.
- Waits for the multiplier to finish, then returns the 64-bit product with a one-cycle done pulse to that requester.
- Sits between requester blocks and the single mult32x32 instance; it is the only driver of the multiplier's start/a/b.

---
 rtl/mult32x32_arbiter.sv | 146 ++++++++++++++
 tb/tb_mult32x32_arbiter.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/mult32x32_arbiter.sv
// Round-robin front end that shares one sequential 32x32 multiplier between
// NUM_REQ requesters: grant, launch, wait for completion, return the product.
module mult32x32_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NUM_REQ-1:0]      req,
  input  logic [NUM_REQ*32-1:0]   a_in,
  input  logic [NUM_REQ*32-1:0]   b_in,
  output logic [NUM_REQ-1:0]      gnt,
  output logic [NUM_REQ-1:0]      done,
  output logic [63:0]             product_out,
  output logic [IDX_W-1:0]        owner,
  output logic                    arb_busy,
  output logic                    mult_start,
  output logic [31:0]             mult_a,
  output logic [31:0]             mult_b,
  input  logic                    mult_busy,
  input  logic [63:0]             mult_product
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_ARM,
    S_WAIT,
    S_DONE
  } state_t;

  state_t               state_q, state_d;
  logic [IDX_W-1:0]     ptr_q, ptr_d;
  logic [IDX_W-1:0]     owner_q, owner_d;
  logic [31:0]          mult_a_q, mult_a_d;
  logic [31:0]          mult_b_q, mult_b_d;
  logic [63:0]          product_q, product_d;
  logic [NUM_REQ-1:0]   done_q, done_d;
  logic                 mult_start_q, mult_start_d;
  logic                 arb_busy_q, arb_busy_d;

  logic [31:0]          a_arr [NUM_REQ];
  logic [31:0]          b_arr [NUM_REQ];
  logic [IDX_W-1:0]     pick_idx;
  logic                 pick_found;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
      assign a_arr[gi] = a_in[32*gi +: 32];
      assign b_arr[gi] = b_in[32*gi +: 32];
    end
  endgenerate

  // First requester at or after the pointer, wrapping at NUM_REQ.
  always_comb begin
    int pos;
    pos        = 0;
    pick_idx   = '0;
    pick_found = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      pos = int'(ptr_q) + k;
      if (pos >= NUM_REQ) pos = pos - NUM_REQ;
      if (!pick_found && req[IDX_W'(pos)]) begin
        pick_found = 1'b1;
        pick_idx   = IDX_W'(pos);
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    ptr_d        = ptr_q;
    owner_d      = owner_q;
    mult_a_d     = mult_a_q;
    mult_b_d     = mult_b_q;
    product_d    = product_q;
    done_d       = '0;
    mult_start_d = 1'b0;
    gnt          = '0;

    case (state_q)
      S_IDLE: begin
        // Grant is combinational, but suppressed while reset is held.
        if (pick_found && !reset) begin
          gnt[pick_idx] = 1'b1;
          owner_d       = pick_idx;
          mult_a_d      = a_arr[pick_idx];
          mult_b_d      = b_arr[pick_idx];
          mult_start_d  = 1'b1;
          state_d       = S_START;
        end
      end
      S_START: state_d = S_ARM;
      // The multiplier has not raised busy yet, so skip one cycle.
      S_ARM:   state_d = S_WAIT;
      S_WAIT: begin
        if (!mult_busy) begin
          product_d       = mult_product;
          done_d[owner_q] = 1'b1;
          state_d         = S_DONE;
        end
      end
      S_DONE: begin
        ptr_d   = (owner_q == IDX_W'(NUM_REQ - 1)) ? '0 : owner_q + 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    arb_busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= S_IDLE;
      ptr_q        <= '0;
      owner_q      <= '0;
      mult_a_q     <= '0;
      mult_b_q     <= '0;
      product_q    <= '0;
      done_q       <= '0;
      mult_start_q <= 1'b0;
      arb_busy_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      ptr_q        <= ptr_d;
      owner_q      <= owner_d;
      mult_a_q     <= mult_a_d;
      mult_b_q     <= mult_b_d;
      product_q    <= product_d;
      done_q       <= done_d;
      mult_start_q <= mult_start_d;
      arb_busy_q   <= arb_busy_d;
    end
  end

  assign done        = done_q;
  assign product_out = product_q;
  assign owner       = owner_q;
  assign arb_busy    = arb_busy_q;
  assign mult_start  = mult_start_q;
  assign mult_a      = mult_a_q;
  assign mult_b      = mult_b_q;

endmodule

// File: tb/tb_mult32x32_arbiter.sv
// Directed + randomized bench for mult32x32_arbiter with a behavioural
// multiplier and a round-robin reference model kept in plain arithmetic.
module tb_mult32x32_arbiter;
  localparam int N = 4;

  logic              clk = 1'b0;
  logic              reset;
  logic [N-1:0]      req;
  logic [N*32-1:0]   a_in, b_in;
  logic [N-1:0]      gnt, done;
  logic [63:0]       product_out;
  logic [1:0]        owner;
  logic              arb_busy, mult_start;
  logic [31:0]       mult_a, mult_b;
  logic              mult_busy;
  logic [63:0]       mult_product;

  logic [31:0]       a_v [N];
  logic [31:0]       b_v [N];
  logic [N-1:0]      req_v;

  int cyc = 0;
  int checks = 0;
  int passes = 0;
  int ptr = 0;
  int last_done = 0;
  int bcycles = 4;
  int done_seen = 0;
  int gnt2_seen = 0;

  always #5 clk = ~clk;

  mult32x32_arbiter #(.NUM_REQ(N)) dut (
    .clk(clk), .reset(reset), .req(req), .a_in(a_in), .b_in(b_in),
    .gnt(gnt), .done(done), .product_out(product_out), .owner(owner),
    .arb_busy(arb_busy), .mult_start(mult_start), .mult_a(mult_a),
    .mult_b(mult_b), .mult_busy(mult_busy), .mult_product(mult_product)
  );

  assign req = req_v;
  always_comb begin
    a_in = '0;
    b_in = '0;
    for (int i = 0; i < N; i++) begin
      a_in[32*i +: 32] = a_v[i];
      b_in[32*i +: 32] = b_v[i];
    end
  end

  // Multiplier: samples start, busy rises one cycle later for bcycles cycles.
  int m_ph, m_cnt;
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_ph <= 0; m_cnt <= 0; mult_busy <= 1'b0; mult_product <= '0;
    end else if (mult_start) begin
      m_ph <= 1; mult_busy <= 1'b0;
      mult_product <= 64'(mult_a) * 64'(mult_b);
    end else if (m_ph == 1) begin
      m_ph <= 2; mult_busy <= 1'b1; m_cnt <= bcycles;
    end else if (m_ph == 2) begin
      if (m_cnt <= 1) begin
        mult_busy <= 1'b0; m_ph <= 0;
      end else begin
        m_cnt <= m_cnt - 1;
      end
    end
  end

  always @(posedge clk) if (|done) done_seen <= done_seen + 1;
  always @(negedge clk) if (gnt[2]) gnt2_seen <= gnt2_seen + 1;

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) passes++;
    else $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
  endtask

  function automatic int pick(input logic [N-1:0] r, input int p);
    for (int k = 0; k < N; k++) begin
      int i;
      i = (p + k) % N;
      if (r[i]) return i;
    end
    return 0;
  endfunction

  task automatic wait_grant(input bit drop, output int win, output int t_g,
                            output logic [63:0] exp_p);
    #1;
    for (int n = 0; n < 100 && gnt == '0; n++) tick();
    chk("gnt_seen", 64'(|gnt), 64'd1);
    win   = pick(req_v, ptr);
    t_g   = cyc;
    exp_p = 64'(a_v[win]) * 64'(b_v[win]);
    chk("gnt_onehot", 64'(gnt), 64'(1) << win);
    tick();
    if (drop) req_v[win] = 1'b0;
    chk("mult_start", 64'(mult_start), 64'd1);
    chk("mult_a", 64'(mult_a), 64'(a_v[win]));
    chk("mult_b", 64'(mult_b), 64'(b_v[win]));
    chk("owner", 64'(owner), 64'(win));
    chk("busy_run", 64'(arb_busy), 64'd1);
    $display("grant req=%0d at cycle %0d a=%0h b=%0h", win, t_g, a_v[win], b_v[win]);
  endtask

  task automatic finish_op(input int win, input int t_g, input logic [63:0] exp_p);
    for (int n = 0; n < 200 && done == '0; n++) tick();
    chk("done_onehot", 64'(done), 64'(1) << win);
    chk("product", product_out, exp_p);
    chk("latency", 64'(cyc - t_g), 64'(bcycles + 4));
    ptr = (win + 1) % N;
    last_done = cyc;
    $display("done  req=%0d at cycle %0d product=%0h", win, cyc, product_out);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int w, tg, ds, g2, early;
    logic [63:0] ep;
    reset = 1'b1;
    req_v = '0;
    for (int i = 0; i < N; i++) begin a_v[i] = '0; b_v[i] = '0; end
    tick(); tick();
    chk("rst_gnt", 64'(gnt), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_start", 64'(mult_start), 64'd0);
    chk("rst_busy", 64'(arb_busy), 64'd0);
    chk("rst_product", product_out, 64'd0);
    chk("rst_owner", 64'(owner), 64'd0);
    reset = 1'b0;
    tick();

    // Single request, 4 busy cycles: done at T+8, idle at T+9.
    a_v[0] = 32'd2; b_v[0] = 32'd3; bcycles = 4; req_v = 4'b0001;
    wait_grant(1'b1, w, tg, ep);
    finish_op(w, tg, ep);
    chk("single_product", product_out, 64'd6);
    tick();
    chk("single_idle", 64'(arb_busy), 64'd0);

    // All four requesting, back-to-back service.
    for (int i = 0; i < N; i++) begin a_v[i] = 32'(i + 1); b_v[i] = 32'd10; end
    bcycles = 2; req_v = 4'b1111;
    for (int k = 0; k < N; k++) begin
      wait_grant(1'b1, w, tg, ep);
      if (k > 0) chk("b2b_gap", 64'(tg), 64'(last_done + 1));
      finish_op(w, tg, ep);
    end

    // Serve 2 alone (pointer -> 3), then 0 and 2: wrap gives 0 first.
    a_v[2] = $urandom; b_v[2] = $urandom; req_v = 4'b0100;
    wait_grant(1'b1, w, tg, ep);
    finish_op(w, tg, ep);
    a_v[0] = $urandom; b_v[0] = $urandom; req_v = 4'b0101;
    wait_grant(1'b1, w, tg, ep);
    chk("wrap_first", 64'(w), 64'd0);
    finish_op(w, tg, ep);
    wait_grant(1'b1, w, tg, ep);
    chk("wrap_second", 64'(w), 64'd2);
    finish_op(w, tg, ep);

    // Maximum operands on requester 3.
    a_v[3] = 32'hFFFF_FFFF; b_v[3] = 32'hFFFF_FFFF; req_v = 4'b1000;
    wait_grant(1'b1, w, tg, ep);
    finish_op(w, tg, ep);
    chk("max_product", product_out, 64'hFFFF_FFFE_0000_0001);

    // Reset in WAIT: outputs clear at once, no done, req[1] later served.
    a_v[1] = $urandom; b_v[1] = $urandom; bcycles = 10; req_v = 4'b0010;
    wait_grant(1'b0, w, tg, ep);
    tick(); tick(); tick();
    ds = done_seen;
    #2 reset = 1'b1;
    #1;
    chk("mid_rst_gnt", 64'(gnt), 64'd0);
    chk("mid_rst_done", 64'(done), 64'd0);
    chk("mid_rst_start", 64'(mult_start), 64'd0);
    chk("mid_rst_busy", 64'(arb_busy), 64'd0);
    chk("mid_rst_product", product_out, 64'd0);
    chk("mid_rst_mult_a", 64'(mult_a), 64'd0);
    chk("mid_rst_mult_b", 64'(mult_b), 64'd0);
    chk("mid_rst_owner", 64'(owner), 64'd0);
    tick(); tick();
    reset = 1'b0;
    ptr = 0;
    chk("mid_rst_no_done", 64'(done_seen), 64'(ds));
    bcycles = 3;
    wait_grant(1'b1, w, tg, ep);
    chk("post_rst_winner", 64'(w), 64'd1);
    finish_op(w, tg, ep);

    // Busy held 20 cycles while req[2] is pulsed and withdrawn.
    a_v[0] = $urandom; b_v[0] = $urandom; bcycles = 20; req_v = 4'b0001;
    g2 = gnt2_seen;
    wait_grant(1'b1, w, tg, ep);
    tick(); tick();
    req_v[2] = 1'b1;
    tick(); tick();
    req_v[2] = 1'b0;
    early = 0;
    while (cyc < tg + 23) begin
      tick();
      if (|done) early++;
    end
    chk("hold_no_done", 64'(early), 64'd0);
    chk("hold_busy", 64'(arb_busy), 64'd1);
    finish_op(w, tg, ep);
    for (int i = 0; i < 5; i++) tick();
    chk("withdrawn_never_granted", 64'(gnt2_seen), 64'(g2));

    // Randomized request masks, operands and busy lengths.
    for (int r = 0; r < 6; r++) begin
      for (int i = 0; i < N; i++) begin a_v[i] = $urandom; b_v[i] = $urandom; end
      bcycles = $urandom_range(1, 6);
      req_v = 4'($urandom_range(1, 15));
      while (req_v != '0) begin
        wait_grant(1'b1, w, tg, ep);
        finish_op(w, tg, ep);
      end
    end

    tick();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
